// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (optional frame counter via VGA_FRAME_COUNTER_EN).
// Latency: 1 clk from a pix_en=1 edge to the new position; all outputs registered.
// Backpressure: pix_en=0 holds every output; line_start/frame_start drop after one clk.
module vga_timing_gen #(
  parameter int activeHvideo = 640,
  parameter int hfp          = 24,
  parameter int hpulse       = 40,
  parameter int hbp          = 128,
  parameter int activeVvideo = 480,
  parameter int vfp          = 9,
  parameter int vpulse       = 2,
  parameter int vbp          = 29,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic        hsync,
  output logic        vsync,
  output logic [10:0] x_px,
  output logic [10:0] y_px,
  output logic        activevideo,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_FRAME_COUNTER_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int HTOTAL = activeHvideo + hfp + hpulse + hbp;
  localparam int VTOTAL = activeVvideo + vfp + vpulse + vbp;

  // 12-bit compare constants so a 2048 total still fits without overflow.
  localparam logic [11:0] H_LAST     = 12'(HTOTAL - 1);
  localparam logic [11:0] H_ACT      = 12'(activeHvideo);
  localparam logic [11:0] H_SYNC_BEG = 12'(activeHvideo + hfp);
  localparam logic [11:0] H_SYNC_END = 12'(activeHvideo + hfp + hpulse);
  localparam logic [11:0] V_LAST     = 12'(VTOTAL - 1);
  localparam logic [11:0] V_ACT      = 12'(activeVvideo);
  localparam logic [11:0] V_SYNC_BEG = 12'(activeVvideo + vfp);
  localparam logic [11:0] V_SYNC_END = 12'(activeVvideo + vfp + vpulse);

  typedef enum logic {
    ST_ARMED,
    ST_RUN
  } state_t;

  state_t      state;
  logic [10:0] x_nxt;
  logic [10:0] y_nxt;
  logic [11:0] xn_e;
  logic [11:0] yn_e;
  logic        x_wrap;
  logic        y_wrap;
  logic        frame_wrap;

  always_comb begin
    x_wrap     = ({1'b0, x_px} == H_LAST);
    y_wrap     = ({1'b0, y_px} == V_LAST);
    x_nxt      = x_wrap ? 11'd0 : x_px + 11'd1;
    y_nxt      = y_px;
    if (x_wrap) begin
      y_nxt = y_wrap ? 11'd0 : y_px + 11'd1;
    end
    frame_wrap = (state == ST_RUN) && x_wrap && y_wrap;
    // The first enabled cycle after reset loads the origin instead of advancing.
    if (state == ST_ARMED) begin
      x_nxt = 11'd0;
      y_nxt = 11'd0;
    end
    xn_e = {1'b0, x_nxt};
    yn_e = {1'b0, y_nxt};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_ARMED;
      x_px        <= 11'd0;
      y_px        <= 11'd0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      activevideo <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
`ifdef VGA_FRAME_COUNTER_EN
      frame_cnt   <= 16'd0;
`endif
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        state       <= ST_RUN;
        x_px        <= x_nxt;
        y_px        <= y_nxt;
        hsync       <= (xn_e >= H_SYNC_BEG && xn_e < H_SYNC_END) ? HSYNC_POL : ~HSYNC_POL;
        vsync       <= (yn_e >= V_SYNC_BEG && yn_e < V_SYNC_END) ? VSYNC_POL : ~VSYNC_POL;
        activevideo <= (xn_e < H_ACT) && (yn_e < V_ACT);
        line_start  <= (x_nxt == 11'd0);
        frame_start <= (x_nxt == 11'd0) && (y_nxt == 11'd0);
`ifdef VGA_FRAME_COUNTER_EN
        if (frame_wrap) begin
          frame_cnt <= frame_cnt + 16'd1;
        end
`endif
      end
    end
  end

`ifndef VGA_FRAME_COUNTER_EN
  logic unused_frame_wrap;
  assign unused_frame_wrap = frame_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: directed and random pix_en/reset against a pixel-index model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  logic        hs_a, vs_a, act_a, ls_a, fs_a;
  logic [10:0] x_a, y_a;
  logic        hs_b, vs_b, act_b, ls_b, fs_b;
  logic [10:0] x_b, y_b;
`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0] fc_a, fc_b;
`endif

  vga_timing_gen #(
    .activeHvideo(8), .hfp(2), .hpulse(3), .hbp(3),
    .activeVvideo(4), .vfp(1), .vpulse(2), .vbp(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hsync(hs_a), .vsync(vs_a), .x_px(x_a), .y_px(y_a),
    .activevideo(act_a), .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_cnt(fc_a)
`endif
  );

  vga_timing_gen #(
    .activeHvideo(8), .hfp(2), .hpulse(3), .hbp(3),
    .activeVvideo(4), .vfp(1), .vpulse(2), .vbp(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_pol (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hsync(hs_b), .vsync(vs_b), .x_px(x_b), .y_px(y_b),
    .activevideo(act_b), .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_cnt(fc_b)
`endif
  );

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // Model: 'tot' is the number of pixels advanced since the origin was loaded.
  bit          run = 1'b0;
  int unsigned tot = 0;
  bit          exp_ls = 1'b0;
  bit          exp_fs = 1'b0;
  int          ex = 0;
  int          ey = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic step(input bit en, input bit rst);
    bit hs_on, vs_on, act;
    reset  = rst;
    pix_en = en;
    @(posedge clk);
    exp_ls = 1'b0;
    exp_fs = 1'b0;
    if (rst) begin
      run = 1'b0;
      tot = 0;
    end else if (en) begin
      if (run) tot++;
      else begin
        run = 1'b1;
        tot = 0;
      end
      exp_ls = (tot % 16) == 0;
      exp_fs = (tot % 128) == 0;
    end
    #1;
    ex    = int'(tot % 16);
    ey    = int'((tot / 16) % 8);
    hs_on = run && ex >= 10 && ex < 13;
    vs_on = run && ey >= 5 && ey < 7;
    act   = run && ex < 8 && ey < 4;
    chk("x_px",        16'(x_a),   16'(ex));
    chk("y_px",        16'(y_a),   16'(ey));
    chk("hsync",       16'(hs_a),  16'(!hs_on));
    chk("vsync",       16'(vs_a),  16'(!vs_on));
    chk("activevideo", 16'(act_a), 16'(act));
    chk("line_start",  16'(ls_a),  16'(exp_ls));
    chk("frame_start", 16'(fs_a),  16'(exp_fs));
    chk("pol_x_px",    16'(x_b),   16'(ex));
    chk("pol_y_px",    16'(y_b),   16'(ey));
    chk("pol_hsync",   16'(hs_b),  16'(hs_on));
    chk("pol_vsync",   16'(vs_b),  16'(vs_on));
    chk("pol_active",  16'(act_b), 16'(act));
    chk("pol_line_st", 16'(ls_b),  16'(exp_ls));
    chk("pol_frame_st",16'(fs_b),  16'(exp_fs));
`ifdef VGA_FRAME_COUNTER_EN
    chk("frame_cnt",     fc_a, 16'((tot / 128) % 65536));
    chk("pol_frame_cnt", fc_b, 16'((tot / 128) % 65536));
`endif
    reset  = 1'b0;
    pix_en = 1'b0;
  endtask

  initial begin
    // Reset held for 3 clk, then a full line and a full frame with constant enable.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 16 + 128 + 4; i++) step(1'b1, 1'b0);

    // Alternating enable: position advances every second clk, strobes last one clk.
    for (int i = 0; i < 40; i++) step(i % 2 == 0, 1'b0);

    // Advance to (6,2) and reset there with enable high: reset wins.
    for (int i = 0; i < 300 && !(ex == 6 && ey == 2); i++) step(1'b1, 1'b0);
    chk("reach_x6", 16'(x_a), 16'd6);
    chk("reach_y2", 16'(y_a), 16'd2);
    step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);

    // Random enable with occasional resets.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 79) == 0);

    // Long enabled run across several frame wraps.
    for (int i = 0; i < 400; i++) step(1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
